// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: Moore sequencing with a Zero-dependent PCWrite in BRANCH.
// Define MCU_IMM_ALU_EN to compile in the I-type ALU path (IEXEC/IWB, ZeroExt).
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALU_Control,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic       Instr_Done,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
`ifdef MCU_IMM_ALU_EN
    , IEXEC = 4'd10,
    IWB    = 4'd11
`endif
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state, next_state;

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  assign State = state;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    next_state  = FETCH;
    ALU_Control = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ZeroExt     = 1'b0;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Illegal     = 1'b0;
    Instr_Done  = 1'b0;

    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_RTYPE:       next_state = EXEC;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_J:           next_state = JUMP;
`ifdef MCU_IMM_ALU_EN
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: next_state = IEXEC;
`endif
          default: begin
            Illegal    = 1'b1;
            Instr_Done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        Instr_Done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        Instr_Done = 1'b1;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        next_state = ALUWB;
        case (Funct)
          6'h20, 6'h21: ALU_Control = ALU_ADD;
          6'h22, 6'h23: ALU_Control = ALU_SUB;
          6'h24:        ALU_Control = ALU_AND;
          6'h25:        ALU_Control = ALU_OR;
          6'h26:        ALU_Control = ALU_XOR;
          6'h27:        ALU_Control = ALU_NOR;
          6'h2A:        ALU_Control = ALU_SLT;
          default: begin
            Illegal    = 1'b1;
            Instr_Done = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        Instr_Done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSource    = 2'b01;
        PCWrite     = (Opcode == OP_BNE) ? ~Zero : Zero;
        Instr_Done  = 1'b1;
      end
      JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        Instr_Done = 1'b1;
      end
`ifdef MCU_IMM_ALU_EN
      IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = IWB;
        case (Opcode)
          OP_SLTI: ALU_Control = ALU_SLT;
          OP_ANDI: begin ALU_Control = ALU_AND; ZeroExt = 1'b1; end
          OP_ORI:  begin ALU_Control = ALU_OR;  ZeroExt = 1'b1; end
          OP_XORI: begin ALU_Control = ALU_XOR; ZeroExt = 1'b1; end
          default: ALU_Control = ALU_ADD;
        endcase
      end
      IWB: begin
        RegWrite   = 1'b1;
        Instr_Done = 1'b1;
        ZeroExt    = (Opcode == OP_ANDI) || (Opcode == OP_ORI) || (Opcode == OP_XORI);
      end
`endif
      default: next_state = FETCH;
    endcase

    // During reset the datapath sees FETCH selects with every side effect suppressed.
    if (reset) begin
      ALU_Control = ALU_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b01;
      ZeroExt     = 1'b0;
      PCSource    = 2'b00;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      Illegal     = 1'b0;
      Instr_Done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: walks each instruction class cycle by cycle.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALU_Control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ZeroExt;
  logic [1:0] PCSource;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       Illegal, Instr_Done;
  logic [3:0] State;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
    .PCSource(PCSource), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Illegal(Illegal), .Instr_Done(Instr_Done), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Side-effect strobes: {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Illegal, Instr_Done}
  logic [6:0] we;
  assign we = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Illegal, Instr_Done};

  localparam logic [6:0] WE_NONE  = 7'b0000000;
  localparam logic [6:0] WE_FETCH = 7'b1110000;
  localparam logic [6:0] WE_MRD   = 7'b0010000;
  localparam logic [6:0] WE_WB    = 7'b0000101;
  localparam logic [6:0] WE_MWR   = 7'b0001001;
  localparam logic [6:0] WE_ILL   = 7'b0000011;
  localparam logic [6:0] WE_PCD   = 7'b1000001;
  localparam logic [6:0] WE_DONE  = 7'b0000001;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] w);
    #1;
    check({tag, ".state"}, {28'd0, State}, {28'd0, st});
    check({tag, ".we"}, {25'd0, we}, {25'd0, w});
  endtask

  // Called in a FETCH cycle; leaves the bench in the DECODE cycle.
  task automatic do_fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    Opcode = op;
    Funct  = fn;
    cyc({tag, ".F"}, 4'd0, WE_FETCH);
    check({tag, ".F.srcb"}, {30'd0, ALUSrcB}, 32'd1);
    tick;
  endtask

  logic [5:0] fn_tab  [7] = '{6'h20, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [3:0] alu_tab [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111};

  initial begin
    reset = 1'b1;
    Opcode = 6'd0;
    Funct = 6'd0;
    Zero = 1'b0;

    tick;
    cyc("rst", 4'd0, WE_NONE);
    check("rst.srcb", {30'd0, ALUSrcB}, 32'd1);
    reset = 1'b0;

    // lw: 5 cycles
    do_fetch("lw", 6'b100011, 6'd0);
    cyc("lw.D", 4'd1, WE_NONE);
    check("lw.D.srcb", {30'd0, ALUSrcB}, 32'd3);
    check("lw.D.alu", {28'd0, ALU_Control}, 32'h2);
    tick;
    cyc("lw.ADR", 4'd2, WE_NONE);
    check("lw.ADR.srca", {31'd0, ALUSrcA}, 32'd1);
    check("lw.ADR.srcb", {30'd0, ALUSrcB}, 32'd2);
    tick;
    cyc("lw.RD", 4'd3, WE_MRD);
    check("lw.RD.iord", {31'd0, IorD}, 32'd1);
    tick;
    cyc("lw.WB", 4'd4, WE_WB);
    check("lw.WB.m2r", {31'd0, MemtoReg}, 32'd1);
    tick;

    // reset for two edges in the middle of MEMRD
    do_fetch("lwr", 6'b100011, 6'd0);
    tick;
    tick;
    cyc("lwr.RD", 4'd3, WE_MRD);
    reset = 1'b1;
    cyc("lwr.rstRD", 4'd3, WE_NONE);
    check("lwr.rstRD.srcb", {30'd0, ALUSrcB}, 32'd1);
    check("lwr.rstRD.iord", {31'd0, IorD}, 32'd0);
    tick;
    cyc("lwr.rst2", 4'd0, WE_NONE);
    tick;
    reset = 1'b0;

    // sw: 4 cycles
    do_fetch("sw", 6'b101011, 6'd0);
    cyc("sw.D", 4'd1, WE_NONE);
    tick;
    cyc("sw.ADR", 4'd2, WE_NONE);
    tick;
    cyc("sw.WR", 4'd5, WE_MWR);
    check("sw.WR.iord", {31'd0, IorD}, 32'd1);
    tick;

    // R-type across the supported functs
    for (int i = 0; i < 7; i++) begin
      do_fetch($sformatf("r%0h", fn_tab[i]), 6'b000000, fn_tab[i]);
      cyc($sformatf("r%0h.D", fn_tab[i]), 4'd1, WE_NONE);
      tick;
      cyc($sformatf("r%0h.EX", fn_tab[i]), 4'd6, WE_NONE);
      check($sformatf("r%0h.EX.alu", fn_tab[i]), {28'd0, ALU_Control}, {28'd0, alu_tab[i]});
      check($sformatf("r%0h.EX.srca", fn_tab[i]), {31'd0, ALUSrcA}, 32'd1);
      tick;
      cyc($sformatf("r%0h.WB", fn_tab[i]), 4'd7, WE_WB);
      check($sformatf("r%0h.WB.regdst", fn_tab[i]), {31'd0, RegDst}, 32'd1);
      tick;
    end

    // illegal funct: flagged in EXEC, no writeback
    do_fetch("r3f", 6'b000000, 6'h3F);
    cyc("r3f.D", 4'd1, WE_NONE);
    tick;
    cyc("r3f.EX", 4'd6, WE_ILL);
    tick;
    cyc("r3f.back", 4'd0, WE_FETCH);

    // beq / bne, Zero swept inside BRANCH
    do_fetch("beq", 6'b000100, 6'd0);
    cyc("beq.D", 4'd1, WE_NONE);
    tick;
    Zero = 1'b1;
    cyc("beq.Z1", 4'd8, WE_PCD);
    check("beq.pcsrc", {30'd0, PCSource}, 32'd1);
    check("beq.alu", {28'd0, ALU_Control}, 32'h6);
    Zero = 1'b0;
    cyc("beq.Z0", 4'd8, WE_DONE);
    tick;

    do_fetch("bne", 6'b000101, 6'd0);
    tick;
    Zero = 1'b1;
    cyc("bne.Z1", 4'd8, WE_DONE);
    Zero = 1'b0;
    cyc("bne.Z0", 4'd8, WE_PCD);
    tick;

    // j
    do_fetch("j", 6'b000010, 6'd0);
    cyc("j.D", 4'd1, WE_NONE);
    tick;
    cyc("j.JMP", 4'd9, WE_PCD);
    check("j.pcsrc", {30'd0, PCSource}, 32'd2);
    tick;

    // unsupported opcode
    do_fetch("op3f", 6'b111111, 6'd0);
    cyc("op3f.D", 4'd1, WE_ILL);
    tick;
    cyc("op3f.back", 4'd0, WE_FETCH);

`ifdef MCU_IMM_ALU_EN
    do_fetch("ori", 6'b001101, 6'd0);
    cyc("ori.D", 4'd1, WE_NONE);
    tick;
    cyc("ori.IEX", 4'd10, WE_NONE);
    check("ori.IEX.alu", {28'd0, ALU_Control}, 32'h1);
    check("ori.IEX.zext", {31'd0, ZeroExt}, 32'd1);
    check("ori.IEX.srcb", {30'd0, ALUSrcB}, 32'd2);
    tick;
    cyc("ori.IWB", 4'd11, WE_WB);
    check("ori.IWB.zext", {31'd0, ZeroExt}, 32'd1);
    check("ori.IWB.regdst", {31'd0, RegDst}, 32'd0);
    tick;

    do_fetch("slti", 6'b001010, 6'd0);
    tick;
    cyc("slti.IEX", 4'd10, WE_NONE);
    check("slti.IEX.alu", {28'd0, ALU_Control}, 32'h7);
    check("slti.IEX.zext", {31'd0, ZeroExt}, 32'd0);
    tick;
    cyc("slti.IWB", 4'd11, WE_WB);
    tick;
`else
    do_fetch("ori", 6'b001101, 6'd0);
    cyc("ori.D", 4'd1, WE_ILL);
    check("ori.D.zext", {31'd0, ZeroExt}, 32'd0);
    tick;
`endif
    cyc("end", 4'd0, WE_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
